// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: FSM encoding, SPI mode and timing limits.
package spi_pkg;

    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    // Mode 0 only: SCK idles low, data sampled on the rising edge.
    localparam bit CPOL = 1'b0;
    localparam bit CPHA = 1'b0;

    localparam int SCK_HALF_MIN = 4;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus a history flop; emits the synced level and
// single-cycle rise/fall strobes.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK50MHZ,
    input  logic RST,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    // sh[0], sh[1] form the synchroniser; sh[2] holds the previous synced level.
    logic [2:0] sh;

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) sh <= {3{RST_VAL}};
        else     sh <= {sh[1:0], din};
    end

    assign lvl  = sh[1];
    assign rise =  sh[1] & ~sh[2];
    assign fall = ~sh[1] &  sh[2];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: deserialises MOSI words, serialises tx_data onto MISO,
// and supports back-to-back words inside one CS-low frame.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK50MHZ,
    input  logic             RST,
    input  logic             spi_sck,
    input  logic             spi_cs,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_load,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_abort,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    // CS idles high, so its synchroniser resets high to avoid a false cs_fall.
    localparam logic [2:0]       RST_LVL = 3'b010;

    logic [2:0] pins, lvl, rise, fall;
    assign pins = {spi_mosi, spi_cs, spi_sck};

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_sync
            sync_edge #(.RST_VAL(RST_LVL[g])) u_sync (
                .CLK50MHZ(CLK50MHZ),
                .RST     (RST),
                .din     (pins[g]),
                .lvl     (lvl[g]),
                .rise    (rise[g]),
                .fall    (fall[g])
            );
        end
    endgenerate

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    assign sck_rise = rise[0];
    assign sck_fall = fall[0];
    assign cs_rise  = rise[1];
    assign cs_fall  = fall[1];
    assign mosi_s   = lvl[2];

    logic             state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] tx_shift, rx_shift, rx_next;
    logic             reload;
    logic [1:0]       vld_pipe;

    assign rx_next  = {rx_shift[WIDTH-2:0], mosi_s};
    assign rx_valid = vld_pipe[1];

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = SHIFT;
            SHIFT:   if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            count       <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            reload      <= 1'b0;
            vld_pipe    <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            tx_load     <= 1'b0;
            rx_abort    <= 1'b0;
        end else begin
            tx_load  <= 1'b0;
            rx_abort <= 1'b0;
            vld_pipe <= {vld_pipe[0], 1'b0};
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        tx_shift    <= tx_data;
                        spi_miso    <= tx_data[WIDTH-1];
                        spi_miso_oe <= 1'b1;
                        tx_load     <= 1'b1;
                        count       <= '0;
                        reload      <= 1'b0;
                    end
                end
                SHIFT: begin
                    // CS deassertion wins over any SCK edge seen in the same cycle.
                    if (cs_rise) begin
                        spi_miso_oe <= 1'b0;
                        spi_miso    <= 1'b0;
                        rx_abort    <= (count != '0);
                        count       <= '0;
                        reload      <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift <= rx_next;
                        if (count == LAST) begin
                            rx_data     <= rx_next;
                            vld_pipe[0] <= 1'b1;
                            count       <= '0;
                            reload      <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else if (sck_fall) begin
                        // The falling edge after a word's last bit starts the next word.
                        if (reload) begin
                            tx_shift <= tx_data;
                            spi_miso <= tx_data[WIDTH-1];
                            tx_load  <= 1'b1;
                            reload   <= 1'b0;
                        end else begin
                            tx_shift <= tx_shift << 1;
                            spi_miso <= tx_shift[WIDTH-2];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lvl[1:0], rise[2], fall[2], tx_shift[WIDTH-1], rx_shift[WIDTH-1]};

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a 32-bit and an 8-bit instance share SCK/MOSI,
// each with its own chip select.
module tb_spi_slave;

    logic        CLK50MHZ = 1'b0;
    logic        RST = 1'b1;
    logic        sck = 1'b0, mosi = 1'b0, cs32 = 1'b1, cs8 = 1'b1;
    logic [31:0] tx32 = 32'h1234_5678;
    logic [7:0]  tx8  = 8'h7E;

    logic        miso32, oe32, tl32, rv32, ab32, busy32;
    logic [31:0] rx32;
    logic        miso8, oe8, tl8, rv8, ab8, busy8;
    logic [7:0]  rx8;

    spi_slave #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK50MHZ(CLK50MHZ), .RST(RST), .spi_sck(sck), .spi_cs(cs32), .spi_mosi(mosi),
        .spi_miso(miso32), .spi_miso_oe(oe32), .tx_data(tx32), .tx_load(tl32),
        .rx_data(rx32), .rx_valid(rv32), .rx_abort(ab32), .busy(busy32)
    );

    spi_slave #(.WIDTH(8), .CNT_W(4)) dut8 (
        .CLK50MHZ(CLK50MHZ), .RST(RST), .spi_sck(sck), .spi_cs(cs8), .spi_mosi(mosi),
        .spi_miso(miso8), .spi_miso_oe(oe8), .tx_data(tx8), .tx_load(tl8),
        .rx_data(rx8), .rx_valid(rv8), .rx_abort(ab8), .busy(busy8)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    int cyc = 0;
    always @(posedge CLK50MHZ) cyc <= cyc + 1;

    // Pulse monitors, sampled on the inactive edge.
    int tl_cnt = 0, rv_cnt = 0, ab_cnt = 0, oe_cnt = 0, rv8_cnt = 0, vld8_cyc = 0;
    logic [31:0] rxq[$];
    always @(negedge CLK50MHZ) begin
        if (tl32) tl_cnt++;
        if (rv32) begin rv_cnt++; rxq.push_back(rx32); end
        if (ab32) ab_cnt++;
        if (oe32) oe_cnt++;
        if (rv8) begin rv8_cnt++; vld8_cyc = cyc; end
    end

    int passed = 0, total = 0;
    int last_rise = 0;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge CLK50MHZ);
    endtask

    // Master side of mode 0: drive MOSI, sample MISO just before SCK rises.
    task automatic spi_bits(input logic [63:0] d, input int n, input int half,
                            input bit use8, output logic [63:0] q);
        q = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            wait_clks(half);
            q = {q[62:0], (use8 ? miso8 : miso32)};
            sck = 1'b1;
            last_rise = cyc;
            wait_clks(half);
            sck = 1'b0;
        end
    endtask

    task automatic test_reset;
        wait_clks(3);
        total++; if (miso32 !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso32); else passed++;
        total++; if (oe32 !== 1'b0) $display("FAIL reset_oe: got %b expected 0", oe32); else passed++;
        total++; if (tl32 !== 1'b0) $display("FAIL reset_tx_load: got %b expected 0", tl32); else passed++;
        total++; if (rv32 !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rv32); else passed++;
        total++; if (ab32 !== 1'b0) $display("FAIL reset_rx_abort: got %b expected 0", ab32); else passed++;
        total++; if (busy32 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy32); else passed++;
        total++; if (rx32 !== 32'h0) $display("FAIL reset_rx_data: got %h expected 0", rx32); else passed++;
        total++; if (oe8 !== 1'b0) $display("FAIL reset_oe8: got %b expected 0", oe8); else passed++;
        RST = 1'b0;
        wait_clks(5);
    endtask

    task automatic test_single;
        logic [63:0] q;
        int tl0, rv0, ab0;
        tl0 = tl_cnt; rv0 = rv_cnt; ab0 = ab_cnt;
        cs32 = 1'b0;
        wait_clks(8);
        total++; if (tl_cnt - tl0 !== 1) $display("FAIL single_tx_load_at_cs: got %0d expected 1", tl_cnt - tl0); else passed++;
        total++; if (oe32 !== 1'b1) $display("FAIL single_oe: got %b expected 1", oe32); else passed++;
        total++; if (busy32 !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy32); else passed++;
        spi_bits(64'hA5C3_0F12, 32, 8, 1'b0, q);
        wait_clks(8);
        cs32 = 1'b1;
        wait_clks(8);
        total++; if (rx32 !== 32'hA5C3_0F12) $display("FAIL single_rx_data: got %h expected a5c30f12", rx32); else passed++;
        total++; if (rv_cnt - rv0 !== 1) $display("FAIL single_rx_valid_cnt: got %0d expected 1", rv_cnt - rv0); else passed++;
        total++; if (q[31:0] !== 32'h1234_5678) $display("FAIL single_miso_word: got %h expected 12345678", q[31:0]); else passed++;
        total++; if (ab_cnt - ab0 !== 0) $display("FAIL single_no_abort: got %0d expected 0", ab_cnt - ab0); else passed++;
        total++; if (oe32 !== 1'b0) $display("FAIL single_oe_after: got %b expected 0", oe32); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] q;
        int tl0, rv0, ab0, base, k;
        tl0 = tl_cnt; rv0 = rv_cnt; ab0 = ab_cnt; base = rxq.size();
        cs32 = 1'b0;
        k = 0;
        while (tl_cnt == tl0 && k < 20) begin wait_clks(1); k++; end
        total++; if (tl_cnt == tl0) $display("FAIL b2b_first_tx_load: got timeout expected pulse"); else passed++;
        tx32 = 32'hCAFE_F00D;
        wait_clks(8);
        spi_bits({32'hDEAD_BEEF, 32'h0000_FFFF}, 64, 8, 1'b0, q);
        wait_clks(8);
        cs32 = 1'b1;
        wait_clks(8);
        total++; if (rv_cnt - rv0 !== 2) $display("FAIL b2b_rx_valid_cnt: got %0d expected 2", rv_cnt - rv0); else passed++;
        total++; if (rxq.size() < base + 2 || rxq[base] !== 32'hDEAD_BEEF)
            $display("FAIL b2b_rx_word0: got %h expected deadbeef", (rxq.size() > base) ? rxq[base] : 32'hx); else passed++;
        total++; if (rxq.size() < base + 2 || rxq[base+1] !== 32'h0000_FFFF)
            $display("FAIL b2b_rx_word1: got %h expected 0000ffff", (rxq.size() > base + 1) ? rxq[base+1] : 32'hx); else passed++;
        total++; if (q[63:32] !== 32'h1234_5678) $display("FAIL b2b_miso_word0: got %h expected 12345678", q[63:32]); else passed++;
        total++; if (q[31:0] !== 32'hCAFE_F00D) $display("FAIL b2b_miso_word1: got %h expected cafef00d", q[31:0]); else passed++;
        total++; if (ab_cnt - ab0 !== 0) $display("FAIL b2b_no_abort: got %0d expected 0", ab_cnt - ab0); else passed++;
    endtask

    task automatic test_abort;
        logic [63:0] q;
        int rv0, ab0;
        rv0 = rv_cnt; ab0 = ab_cnt;
        cs32 = 1'b0;
        wait_clks(8);
        spi_bits(64'h2AA, 10, 8, 1'b0, q);
        wait_clks(8);
        cs32 = 1'b1;
        wait_clks(8);
        total++; if (ab_cnt - ab0 !== 1) $display("FAIL abort_pulse: got %0d expected 1", ab_cnt - ab0); else passed++;
        total++; if (rv_cnt - rv0 !== 0) $display("FAIL abort_no_valid: got %0d expected 0", rv_cnt - rv0); else passed++;
        total++; if (rx32 !== 32'h0000_FFFF) $display("FAIL abort_rx_hold: got %h expected 0000ffff", rx32); else passed++;
        total++; if (oe32 !== 1'b0) $display("FAIL abort_oe: got %b expected 0", oe32); else passed++;
        total++; if (busy32 !== 1'b0) $display("FAIL abort_idle: got %b expected 0", busy32); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [63:0] q;
        int rv0, ab0;
        cs32 = 1'b0;
        wait_clks(8);
        spi_bits(64'h1_5A5A, 17, 8, 1'b0, q);
        RST = 1'b1;
        #1;
        total++; if (oe32 !== 1'b0) $display("FAIL rstmid_oe: got %b expected 0", oe32); else passed++;
        total++; if (busy32 !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy32); else passed++;
        total++; if (rx32 !== 32'h0) $display("FAIL rstmid_rx_data: got %h expected 0", rx32); else passed++;
        total++; if (miso32 !== 1'b0) $display("FAIL rstmid_miso: got %b expected 0", miso32); else passed++;
        cs32 = 1'b1;
        wait_clks(4);
        RST = 1'b0;
        wait_clks(8);
        rv0 = rv_cnt; ab0 = ab_cnt;
        cs32 = 1'b0;
        wait_clks(8);
        spi_bits(64'h1, 32, 8, 1'b0, q);
        wait_clks(8);
        cs32 = 1'b1;
        wait_clks(8);
        total++; if (rx32 !== 32'h0000_0001) $display("FAIL rstmid_fresh_rx: got %h expected 00000001", rx32); else passed++;
        total++; if (rv_cnt - rv0 !== 1) $display("FAIL rstmid_valid_cnt: got %0d expected 1", rv_cnt - rv0); else passed++;
        total++; if (q[31:0] !== 32'hCAFE_F00D) $display("FAIL rstmid_miso_word: got %h expected cafef00d", q[31:0]); else passed++;
        total++; if (ab_cnt - ab0 !== 0) $display("FAIL rstmid_no_abort: got %0d expected 0", ab_cnt - ab0); else passed++;
    endtask

    task automatic test_idle_noise;
        logic [63:0] q;
        int tl0, rv0, ab0, oe0;
        tl0 = tl_cnt; rv0 = rv_cnt; ab0 = ab_cnt; oe0 = oe_cnt;
        spi_bits(64'hB3, 8, 4, 1'b0, q);
        wait_clks(8);
        total++; if (tl_cnt - tl0 !== 0) $display("FAIL noise_tx_load: got %0d expected 0", tl_cnt - tl0); else passed++;
        total++; if (rv_cnt - rv0 !== 0) $display("FAIL noise_rx_valid: got %0d expected 0", rv_cnt - rv0); else passed++;
        total++; if (ab_cnt - ab0 !== 0) $display("FAIL noise_rx_abort: got %0d expected 0", ab_cnt - ab0); else passed++;
        total++; if (oe_cnt - oe0 !== 0) $display("FAIL noise_oe_cycles: got %0d expected 0", oe_cnt - oe0); else passed++;
    endtask

    task automatic test_width8;
        logic [63:0] q;
        int rv0, lat;
        rv0 = rv8_cnt;
        cs8 = 1'b0;
        wait_clks(8);
        spi_bits(64'h81, 8, 4, 1'b1, q);
        wait_clks(8);
        cs8 = 1'b1;
        wait_clks(8);
        lat = vld8_cyc - last_rise;
        total++; if (rx8 !== 8'h81) $display("FAIL w8_rx_data: got %h expected 81", rx8); else passed++;
        total++; if (rv8_cnt - rv0 !== 1) $display("FAIL w8_valid_cnt: got %0d expected 1", rv8_cnt - rv0); else passed++;
        total++; if (q[7:0] !== 8'h7E) $display("FAIL w8_miso_byte: got %h expected 7e", q[7:0]); else passed++;
        total++; if (lat < 3 || lat > 5) $display("FAIL w8_latency: got %0d expected 4+-1", lat); else passed++;
        total++; if (oe8 !== 1'b0) $display("FAIL w8_oe_after: got %b expected 0", oe8); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_idle_noise();
        test_width8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
